// File: rtl/id_ex_skid_pkg.sv
// Shared decode-bundle definition for the ID/EX skid buffer: field widths,
// NOP encodings, bundle pack/unpack helpers and pointer sizing.
package id_ex_skid_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int OPCODE_W    = 7;
  localparam int OPT_W       = 10;
  localparam int REG_W       = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int DATA_F_W    = 32;
  localparam int SHAMT_W     = 5;

  localparam logic [OPCODE_W-1:0] OPCODE_NOP = 7'h13;
  localparam logic [OPT_W-1:0]    OPT_NOP    = 10'h001;

  typedef struct packed {
    logic                   prediction;
    logic [INST_ADDR_W-1:0] pc;
    logic [OPCODE_W-1:0]    opcode;
    logic [OPT_W-1:0]       opt;
    logic [REG_W-1:0]       rdata1;
    logic [REG_W-1:0]       rdata2;
    logic                   we;
    logic [REG_ADDR_W-1:0]  waddr;
    logic [DATA_F_W-1:0]    imm;
    logic [SHAMT_W-1:0]     shamt;
  } decode_t;

  localparam int BUNDLE_W = $bits(decode_t);

  localparam decode_t NOP_DECODE = '{
    prediction: 1'b0, pc: '0, opcode: OPCODE_NOP, opt: OPT_NOP,
    rdata1: '0, rdata2: '0, we: 1'b0, waddr: '0, imm: '0, shamt: '0
  };
  localparam logic [BUNDLE_W-1:0] NOP_BUNDLE = NOP_DECODE;

  function automatic logic [BUNDLE_W-1:0] pack_decode(input decode_t d);
    return d;
  endfunction

  function automatic decode_t unpack_decode(input logic [BUNDLE_W-1:0] v);
    return decode_t'(v);
  endfunction

  // Pointer width stays at least one bit so DEPTH=1 still has a legal index.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/id_ex_skid_fifo_ctrl.sv
// Circular-buffer control for the ID/EX skid buffer: pointers, occupancy,
// handshake qualification and flush.
module pipe_fifo_ctrl
  import id_ex_skid_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int PTR_W   = ptr_width(DEPTH),
  parameter int COUNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic             in_ready,
  output logic             out_valid,
  output logic             push,
  output logic             pop,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr
);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready/valid come from registered occupancy only; out_ready never reaches in_ready.
  assign in_ready  = (count_q != COUNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign wr_ptr    = wr_ptr_q;
  assign rd_ptr    = rd_ptr_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + COUNT_W'(1);
        2'b01:   count_d = count_q - COUNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/id_ex_skid.sv
// ID/EX skid buffer: DEPTH-entry ring between decode and execute with flush,
// NOP substitution when empty and a saturating bubble counter.
module id_ex_skid
  import id_ex_skid_pkg::*;
#(
  parameter int                DATA_W  = BUNDLE_W,
  parameter int                DEPTH   = 2,
  parameter logic [DATA_W-1:0] NOP_VAL = NOP_BUNDLE,
  parameter int                CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic             push, pop;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  pipe_fifo_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .flush     (flush),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .push      (push),
    .pop       (pop),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr)
  );

  // NOTE: storage has no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= in_data;
  end

  assign out_data = out_valid ? mem_q[rd_ptr] : NOP_VAL;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (out_ready && !out_valid && !flush && (bubble_cnt_q != '1))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bubble_cnt_q <= '0;
    else     bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_skid.sv
// Directed bench for id_ex_skid: DEPTH=2 main instance, DEPTH=3 wrap instance,
// CNT_W=4 counter-saturation instance.
module tb_id_ex_skid;
  import id_ex_skid_pkg::*;

  localparam int W = BUNDLE_W;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [31:0] pc);
    decode_t d;
    d.prediction = pc[2];
    d.pc         = pc;
    d.opcode     = 7'h33;
    d.opt        = pc[9:0];
    d.rdata1     = ~pc;
    d.rdata2     = pc ^ 32'h5a5a_5a5a;
    d.we         = 1'b1;
    d.waddr      = pc[6:2];
    d.imm        = {pc[15:0], 16'hbeef};
    d.shamt      = pc[4:0];
    return pack_decode(d);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Instance A: DEPTH=2, default counter
  logic          a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic [W-1:0]  a_in_data, a_out_data;
  logic [15:0]   a_bubble;

  id_ex_skid #(.DEPTH(2)) dut_a (
    .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .flush(a_flush), .bubble_cnt(a_bubble)
  );

  // Instance B: DEPTH=3 for pointer wrap
  logic          bc_rst;
  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [W-1:0]  b_in_data, b_out_data;
  logic [15:0]   b_bubble;

  id_ex_skid #(.DEPTH(3)) dut_b (
    .clk(clk), .rst(bc_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .flush(b_flush), .bubble_cnt(b_bubble)
  );

  // Instance C: CNT_W=4 for saturation
  logic          c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_flush;
  logic [W-1:0]  c_in_data, c_out_data;
  logic [3:0]    c_bubble;

  id_ex_skid #(.DEPTH(2), .CNT_W(4)) dut_c (
    .clk(clk), .rst(bc_rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .flush(c_flush), .bubble_cnt(c_bubble)
  );

  logic [W-1:0] q[$];
  logic [31:0]  pat;
  int sent, recv;

  initial begin
    a_rst = 1'b1; bc_rst = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_flush = 1'b0; a_in_data = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_flush = 1'b0; b_in_data = '0;
    c_in_valid = 1'b0; c_out_ready = 1'b0; c_flush = 1'b0; c_in_data = '0;
    #12;
    a_rst = 1'b0; bc_rst = 1'b0;
    #1;
    check("rst_out_valid", W'(a_out_valid), W'(0));
    check("rst_in_ready",  W'(a_in_ready),  W'(1));
    check("rst_out_data",  a_out_data,      NOP_BUNDLE);
    check("rst_bubble",    W'(a_bubble),    W'(0));

    // One empty cycle with ex ready counts a bubble.
    a_out_ready = 1'b1;
    cyc();
    check("bubble_first", W'(a_bubble), W'(1));
    a_out_ready = 1'b0;

    // Fill to count=2, then reset asynchronously between edges.
    a_in_valid = 1'b1; a_in_data = mk(32'h100);
    cyc();
    a_in_data = mk(32'h104);
    cyc();
    a_in_valid = 1'b0;
    check("full_in_ready",  W'(a_in_ready),  W'(0));
    check("full_out_valid", W'(a_out_valid), W'(1));
    check("full_head",      a_out_data,      mk(32'h100));
    #2 a_rst = 1'b1;
    #1;
    check("arst_out_valid", W'(a_out_valid), W'(0));
    check("arst_in_ready",  W'(a_in_ready),  W'(1));
    check("arst_out_data",  a_out_data,      NOP_BUNDLE);
    check("arst_bubble",    W'(a_bubble),    W'(0));
    cyc();
    a_rst = 1'b0;

    // Streaming: one bundle per cycle, one-cycle latency.
    a_out_ready = 1'b1; a_in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_in_data = mk(32'(4 * i));
      cyc();
      check("stream_valid", W'(a_out_valid), W'(1));
      check("stream_data",  a_out_data,      mk(32'(4 * i)));
      check("stream_ready", W'(a_in_ready),  W'(1));
    end
    a_in_valid = 1'b0;
    cyc();
    a_out_ready = 1'b0;
    check("stream_drain_valid", W'(a_out_valid), W'(0));
    check("stream_drain_nop",   a_out_data,      NOP_BUNDLE);
    check("stream_bubble",      W'(a_bubble),    W'(1));

    // Backpressure: ex stalled for three cycles.
    a_in_valid = 1'b1; a_in_data = mk(32'h10);
    cyc();
    check("bp_ready_1", W'(a_in_ready), W'(1));
    a_in_data = mk(32'h14);
    cyc();
    check("bp_ready_2", W'(a_in_ready), W'(0));
    a_in_data = mk(32'h18);
    cyc();
    check("bp_ready_3", W'(a_in_ready), W'(0));
    check("bp_head",    a_out_data,     mk(32'h10));
    a_out_ready = 1'b1;
    cyc();
    check("bp_rel_data",  a_out_data,     mk(32'h14));
    check("bp_rel_ready", W'(a_in_ready), W'(1));
    cyc();
    a_in_valid = 1'b0;
    check("bp_late_data", a_out_data, mk(32'h18));
    cyc();
    a_out_ready = 1'b0;
    check("bp_empty", W'(a_out_valid), W'(0));
    check("bp_bubble", W'(a_bubble), W'(1));

    // Flush kills buffered and incoming bundles.
    a_in_valid = 1'b1; a_in_data = mk(32'h20);
    cyc();
    a_in_data = mk(32'h24);
    cyc();
    check("fl_head", a_out_data, mk(32'h20));
    a_in_data = mk(32'h28); a_flush = 1'b1; a_out_ready = 1'b1;
    cyc();
    a_flush = 1'b0; a_in_valid = 1'b0;
    check("fl_valid",  W'(a_out_valid), W'(0));
    check("fl_ready",  W'(a_in_ready),  W'(1));
    check("fl_nop",    a_out_data,      NOP_BUNDLE);
    check("fl_bubble", W'(a_bubble),    W'(1));
    cyc();
    check("fl_after_valid", W'(a_out_valid), W'(0));
    cyc();
    check("fl_after_valid", W'(a_out_valid), W'(0));
    check("fl_after_bubble", W'(a_bubble), W'(3));
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = mk(32'h2c);
    cyc();
    a_in_valid = 1'b0;
    check("fl_resume_valid", W'(a_out_valid), W'(1));
    check("fl_resume_data",  a_out_data,      mk(32'h2c));

    // Wrap on DEPTH=3 with irregular ex readiness.
    pat = 32'hFFFF_74D0;
    sent = 0; recv = 0;
    for (int c = 0; c < 80 && recv < 10; c++) begin
      b_in_valid  = (sent < 10);
      b_in_data   = mk(32'h200 + 32'(4 * sent));
      b_out_ready = (c < 32) ? pat[c] : 1'b1;
      #1;
      check("wrap_in_ready",  W'(b_in_ready),  W'(q.size() < 3));
      check("wrap_out_valid", W'(b_out_valid), W'(q.size() != 0));
      if (b_out_valid && b_out_ready && q.size() > 0) begin
        check("wrap_order", b_out_data, q[0]);
        void'(q.pop_front());
        recv++;
      end
      if (b_in_valid && b_in_ready) begin
        q.push_back(b_in_data);
        sent++;
      end
      cyc();
    end
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    check("wrap_recv", W'(recv), W'(10));
    check("wrap_sent", W'(sent), W'(10));

    // Bubble counter saturation on CNT_W=4.
    c_out_ready = 1'b1;
    repeat (5) cyc();
    check("cnt_5", W'(c_bubble), W'(5));
    c_flush = 1'b1;
    cyc();
    c_flush = 1'b0;
    check("cnt_flush", W'(c_bubble), W'(5));
    repeat (9) cyc();
    check("cnt_14", W'(c_bubble), W'(14));
    cyc();
    check("cnt_15", W'(c_bubble), W'(15));
    repeat (10) cyc();
    check("cnt_sat", W'(c_bubble), W'(15));
    c_out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
